// File: rtl/memtile_delay_pkg.sv
// Shared widths, constants and helpers for the parametrised delay-line memtile.
package memtile_delay_pkg;

    localparam int MIN_DELAY = 1;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One extra bit so the delay register can hold DEPTH itself.
    function automatic int dly_w(input int depth);
        return ptr_w(depth) + 1;
    endfunction

endpackage

// File: rtl/memtile_param_delay_line_if.sv
// Stream, configuration and status signals of the delay line, bundled for port use.
interface memtile_param_delay_line_if #(
    parameter int CHANNELS = 1,
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 64
);
    import memtile_delay_pkg::*;

    localparam int DLY_W = dly_w(DEPTH);

    logic                           flush;
    logic                           clk_en;
    logic                           cfg_load;
    logic [DLY_W-1:0]               cfg_delay;
    logic                           cfg_clamped;
    logic                           valid_in;
    logic [CHANNELS-1:0][WIDTH-1:0] data_in;
    logic                           valid_out;
    logic [CHANNELS-1:0][WIDTH-1:0] data_out;

    modport master (
        output flush, clk_en, cfg_load, cfg_delay, valid_in, data_in,
        input  cfg_clamped, valid_out, data_out
    );

    modport slave (
        input  flush, clk_en, cfg_load, cfg_delay, valid_in, data_in,
        output cfg_clamped, valid_out, data_out
    );

endinterface

// File: rtl/memtile_delay_sram.sv
// Simple dual-port 1R1W buffer with registered read output; contents are never reset.
module memtile_delay_sram #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int WORD_W = 17
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/memtile_param_delay_line.sv
// Multi-lane delay line: circular buffer with runtime delay 1..DEPTH, D=1 bypass and priming mask.
module memtile_param_delay_line
    import memtile_delay_pkg::*;
#(
    parameter int CHANNELS      = 1,
    parameter int WIDTH         = 16,
    parameter int DEPTH         = 64,
    parameter int DEFAULT_DELAY = 62
) (
    input  logic                      clk,
    input  logic                      rst,
    memtile_param_delay_line_if.slave bus
);

    localparam int PTR_W  = ptr_w(DEPTH);
    localparam int DLY_W  = dly_w(DEPTH);
    localparam int WORD_W = CHANNELS * WIDTH + 1;

    typedef struct packed {
        logic                           valid;
        logic [CHANNELS-1:0][WIDTH-1:0] data;
    } word_t;

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [DLY_W-1:0] delay_reg, delay_next;
    logic [DLY_W-1:0] prime_cnt_reg, prime_cnt_next;
    logic             cfg_clamped_reg, cfg_clamped_next;
    word_t            bypass_reg;

    word_t            wr_word, rd_word, stored_word;
    logic [DLY_W-1:0] cfg_clamp_val, rd_sum;
    logic [PTR_W-1:0] rd_addr;
    logic             cfg_oor, advance, use_bypass, valid_out;

    // flush and cfg_load both take the cycle over, so no word is accepted alongside them.
    assign advance    = bus.clk_en && !bus.cfg_load && !bus.flush && !rst;
    assign use_bypass = (delay_reg == DLY_W'(MIN_DELAY));
    assign wr_word    = {bus.valid_in, bus.data_in};

    always_comb begin
        cfg_oor       = 1'b0;
        cfg_clamp_val = bus.cfg_delay;
        if (bus.cfg_delay < DLY_W'(MIN_DELAY)) begin
            cfg_oor       = 1'b1;
            cfg_clamp_val = DLY_W'(MIN_DELAY);
        end else if (bus.cfg_delay > DLY_W'(DEPTH)) begin
            cfg_oor       = 1'b1;
            cfg_clamp_val = DLY_W'(DEPTH);
        end
    end

    // rd = wr - (D-1) mod DEPTH; modular wrap of the DLY_W sum keeps the result in range.
    assign rd_sum  = DLY_W'(wr_ptr_reg) + DLY_W'(DEPTH) + DLY_W'(1) - delay_reg;
    assign rd_addr = (rd_sum >= DLY_W'(DEPTH)) ? PTR_W'(rd_sum - DLY_W'(DEPTH)) : PTR_W'(rd_sum);

    always_comb begin
        wr_ptr_next      = wr_ptr_reg;
        delay_next       = delay_reg;
        prime_cnt_next   = prime_cnt_reg;
        cfg_clamped_next = cfg_clamped_reg;
        if (bus.flush) begin
            wr_ptr_next      = '0;
            delay_next       = DLY_W'(DEFAULT_DELAY);
            prime_cnt_next   = '0;
            cfg_clamped_next = 1'b0;
        end else if (bus.cfg_load) begin
            delay_next       = cfg_clamp_val;
            prime_cnt_next   = '0;
            cfg_clamped_next = cfg_clamped_reg | cfg_oor;
        end else if (bus.clk_en) begin
            wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
            if (prime_cnt_reg != delay_reg) begin
                prime_cnt_next = prime_cnt_reg + DLY_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg      <= '0;
            delay_reg       <= DLY_W'(DEFAULT_DELAY);
            prime_cnt_reg   <= '0;
            cfg_clamped_reg <= 1'b0;
        end else begin
            wr_ptr_reg      <= wr_ptr_next;
            delay_reg       <= delay_next;
            prime_cnt_reg   <= prime_cnt_next;
            cfg_clamped_reg <= cfg_clamped_next;
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            bypass_reg <= wr_word;
        end
    end

    memtile_delay_sram #(
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W),
        .WORD_W (WORD_W)
    ) u_sram (
        .clk   (clk),
        .we    (advance),
        .waddr (wr_ptr_reg),
        .wdata (wr_word),
        .re    (advance && !use_bypass),
        .raddr (rd_addr),
        .rdata (rd_word)
    );

    assign stored_word     = use_bypass ? bypass_reg : rd_word;
    assign valid_out       = stored_word.valid && (prime_cnt_reg == delay_reg);
    assign bus.valid_out   = valid_out;
    assign bus.cfg_clamped = cfg_clamped_reg;

    genvar gi;
    for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
        assign bus.data_out[gi] = valid_out ? stored_word.data[gi] : '0;
    end

endmodule
